// File: rtl/pipeline_types.sv
// Types and sizing shared by the fetch controller and the instruction buffer.
package pipeline_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_ctrl_state_t;

    localparam int FETCH_WIDTH       = 2;
    localparam int INST_BUFFER_DEPTH = 32;
    localparam int OCC_W             = 6;
    localparam int MAX_INFLIGHT      = 3;

endpackage

// File: rtl/ibuf_fetch_ctrl_if.sv
// Fetch/push/send control bundle between the fetch controller and its neighbours.
// master is the controller side; slave is the BPU/icache/buffer/decode side.
interface ibuf_fetch_ctrl_if
    import pipeline_types::*;
#(
    parameter int OCC_W = pipeline_types::OCC_W
);
    logic                                flush;
    logic                                stall;
    logic                                pause;
    logic                                pc_valid;
    logic                                fetch_issue;
    logic                                resp_valid;
    logic [FETCH_WIDTH-1:0]              resp_slot_en;
    logic [FETCH_WIDTH-1:0]              icache_fetch_inst_en;
    logic [FETCH_WIDTH-1:0]              issue_ready;
    logic [FETCH_WIDTH-1:0]              send_inst_en;
    logic [FETCH_WIDTH-1:0][OCC_W-1:0]   occ;
    logic [1:0]                          inflight;
    logic                                draining;
    logic                                overflow_err;

    modport master (
        input  flush, stall, pause, pc_valid, resp_valid, resp_slot_en, issue_ready,
        output fetch_issue, icache_fetch_inst_en, send_inst_en, occ, inflight,
               draining, overflow_err
    );

    modport slave (
        output flush, stall, pause, pc_valid, resp_valid, resp_slot_en, issue_ready,
        input  fetch_issue, icache_fetch_inst_en, send_inst_en, occ, inflight,
               draining, overflow_err
    );

endinterface

// File: rtl/ibuf_fetch_ctrl_occ_counter.sv
// Saturating up/down occupancy mirror for one buffer bank; sticky error on push into a full bank.
// Registered count, one-cycle update; clear wins over inc/dec, error survives clear.
module occ_counter #(
    parameter int DEPTH = 32,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         err
);
    localparam logic [W-1:0] FULL = W'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt == FULL) begin
                err <= 1'b1;
            end else begin
                cnt <= cnt + W'(1);
            end
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/ibuf_fetch_ctrl.sv
// Credit-based sequencer for the two-bank instruction buffer: fetch issue, push and send enables.
// Enables are combinational on current inputs; stall blocks all three, pause blocks send only.
module ibuf_fetch_ctrl
    import pipeline_types::*;
#(
    parameter int BUF_DEPTH    = INST_BUFFER_DEPTH,
    parameter int MAX_INFLIGHT = pipeline_types::MAX_INFLIGHT,
    parameter int OCC_W        = pipeline_types::OCC_W
) (
    input  logic               clk,
    input  logic               rst,
    ibuf_fetch_ctrl_if.master  bus
);
    fetch_ctrl_state_t      state_q, state_d;
    logic [1:0]             inflight_q, inflight_d;
    logic [OCC_W-1:0]       occ0, occ1, occ_max;
    logic [OCC_W:0]         committed;
    logic                   credit_ok, resp_take, run;
    logic                   issue, draining;
    logic [FETCH_WIDTH-1:0] push, send;
    logic                   err0, err1;

    assign run       = (state_q == RUN);
    assign resp_take = bus.resp_valid && (inflight_q != 2'd0);
    assign occ_max   = (occ0 > occ1) ? occ0 : occ1;
    // Every outstanding pair must still find a free slot in the fuller bank.
    assign committed = {1'b0, occ_max} + (OCC_W+1)'(inflight_q);
    assign credit_ok = committed < (OCC_W+1)'(BUF_DEPTH);

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !resp_take) begin
            inflight_d = inflight_q + 2'd1;
        end else if (resp_take && !issue) begin
            inflight_d = inflight_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = (state_q == DRAIN || inflight_d != 2'd0) ? DRAIN : RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = RUN;
                DRAIN:   state_d = (inflight_q == 2'd0) ? RUN : DRAIN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        issue    = 1'b0;
        push     = '0;
        send     = '0;
        draining = (state_q == DRAIN);
        if (run && !bus.stall && !bus.flush) begin
            issue   = bus.pc_valid && (inflight_q < 2'(MAX_INFLIGHT)) && credit_ok;
            push    = bus.resp_valid ? bus.resp_slot_en : '0;
            send[0] = !bus.pause && (occ0 != '0) && bus.issue_ready[0];
            // Slot 1 only rides along with slot 0 so decode sees program order.
            send[1] = send[0] && (occ1 != '0) && bus.issue_ready[1];
        end
    end

    occ_counter #(.DEPTH(BUF_DEPTH), .W(OCC_W)) u_occ0 (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .inc (push[0]),
        .dec (send[0]),
        .cnt (occ0),
        .err (err0)
    );

    occ_counter #(.DEPTH(BUF_DEPTH), .W(OCC_W)) u_occ1 (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .inc (push[1]),
        .dec (send[1]),
        .cnt (occ1),
        .err (err1)
    );

    assign bus.fetch_issue          = issue;
    assign bus.icache_fetch_inst_en = push;
    assign bus.send_inst_en         = send;
    assign bus.occ[0]               = occ0;
    assign bus.occ[1]               = occ1;
    assign bus.inflight             = inflight_q;
    assign bus.draining             = draining;
    assign bus.overflow_err         = err0 | err1;

endmodule

// File: tb/tb_ibuf_fetch_ctrl.sv
// Directed bench for ibuf_fetch_ctrl with hand-computed expectations.
module tb_ibuf_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   issues;
    logic prev;

    always #5 clk = ~clk;

    ibuf_fetch_ctrl_if bus ();

    ibuf_fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.flush = 1'b0;        bus.stall = 1'b0;       bus.pause = 1'b0;
        bus.pc_valid = 1'b1;     bus.resp_valid = 1'b0;  bus.resp_slot_en = 2'b00;
        bus.issue_ready = 2'b11;
        #2;
        chk("rst_issue",    32'(bus.fetch_issue), 0);
        chk("rst_send",     32'(bus.send_inst_en), 0);
        chk("rst_occ0",     32'(bus.occ[0]), 0);
        chk("rst_inflight", 32'(bus.inflight), 0);
        chk("rst_drain",    32'(bus.draining), 0);
        chk("rst_ovf",      32'(bus.overflow_err), 0);
        tick();
        bus.issue_ready = 2'b00;
        rst = 1'b0;

        // Fill both banks with back-to-back fetches answered the next cycle.
        issues = 0;
        prev   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.resp_valid   = prev;
            bus.resp_slot_en = 2'b11;
            #1;
            if (bus.fetch_issue) issues++;
            prev = bus.fetch_issue;
            tick();
        end
        bus.resp_valid = 1'b0;
        #1;
        chk("fill_issues",   32'(issues), 32);
        chk("fill_occ0",     32'(bus.occ[0]), 32);
        chk("fill_occ1",     32'(bus.occ[1]), 32);
        chk("fill_issue_lo", 32'(bus.fetch_issue), 0);
        chk("fill_inflight", 32'(bus.inflight), 0);
        chk("fill_ovf",      32'(bus.overflow_err), 0);

        // One send from a full buffer frees a credit.
        bus.issue_ready = 2'b11;
        #1;
        chk("full_send", 32'(bus.send_inst_en), 3);
        tick();
        bus.issue_ready = 2'b00;
        bus.pc_valid    = 1'b1;
        #1;
        chk("send_occ0",   32'(bus.occ[0]), 31);
        chk("send_occ1",   32'(bus.occ[1]), 31);
        chk("reissue",     32'(bus.fetch_issue), 1);
        bus.pc_valid = 1'b0;
        bus.flush    = 1'b1;
        #1;
        chk("flush_no_issue", 32'(bus.fetch_issue), 0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("flush_occ0",  32'(bus.occ[0]), 0);
        chk("flush_occ1",  32'(bus.occ[1]), 0);
        chk("flush_run",   32'(bus.draining), 0);

        // Three outstanding fetches, then flush before any response.
        bus.pc_valid = 1'b1;
        tick(); tick(); tick();
        chk("three_inflight", 32'(bus.inflight), 3);
        chk("max_inflight",   32'(bus.fetch_issue), 0);
        bus.pc_valid = 1'b0;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        chk("drain_enter", 32'(bus.draining), 1);
        chk("drain_occ0",  32'(bus.occ[0]), 0);
        for (int i = 0; i < 3; i++) begin
            bus.resp_valid   = 1'b1;
            bus.resp_slot_en = 2'b11;
            #1;
            chk("drain_push", 32'(bus.icache_fetch_inst_en), 0);
            tick();
        end
        bus.resp_valid = 1'b0;
        #1;
        chk("drain_inflight0", 32'(bus.inflight), 0);
        chk("drain_hold",      32'(bus.draining), 1);
        tick();
        chk("drain_exit", 32'(bus.draining), 0);

        // occ0=2, occ1=0: slot 1 must not be sent alone; pause blocks send.
        bus.resp_valid   = 1'b1;
        bus.resp_slot_en = 2'b01;
        #1;
        chk("push_slot0", 32'(bus.icache_fetch_inst_en), 1);
        tick(); tick();
        bus.resp_valid = 1'b0;
        #1;
        chk("occ0_two", 32'(bus.occ[0]), 2);
        chk("occ1_zero", 32'(bus.occ[1]), 0);
        bus.issue_ready = 2'b11;
        bus.pause       = 1'b1;
        #1;
        chk("pause_send", 32'(bus.send_inst_en), 0);
        bus.pause = 1'b0;
        #1;
        chk("order_send", 32'(bus.send_inst_en), 1);
        bus.issue_ready = 2'b00;

        // Bring occ0 to 5, then push and send in the same cycle.
        bus.resp_valid   = 1'b1;
        bus.resp_slot_en = 2'b01;
        tick(); tick(); tick();
        bus.issue_ready = 2'b01;
        #1;
        chk("both_push", 32'(bus.icache_fetch_inst_en), 1);
        chk("both_send", 32'(bus.send_inst_en), 1);
        tick();
        bus.resp_valid  = 1'b0;
        bus.issue_ready = 2'b00;
        #1;
        chk("both_occ0", 32'(bus.occ[0]), 5);

        // Issue and response in the same cycle leave inflight alone.
        bus.pc_valid = 1'b1;
        tick();
        bus.resp_valid   = 1'b1;
        bus.resp_slot_en = 2'b00;
        #1;
        chk("sim_issue", 32'(bus.fetch_issue), 1);
        tick();
        bus.pc_valid   = 1'b0;
        bus.resp_valid = 1'b0;
        #1;
        chk("sim_inflight", 32'(bus.inflight), 1);

        // A stalled response is dropped but still retires the fetch.
        bus.stall        = 1'b1;
        bus.resp_valid   = 1'b1;
        bus.resp_slot_en = 2'b11;
        #1;
        chk("stall_push", 32'(bus.icache_fetch_inst_en), 0);
        tick();
        bus.stall      = 1'b0;
        bus.resp_valid = 1'b0;
        #1;
        chk("stall_inflight", 32'(bus.inflight), 0);
        chk("stall_occ0",     32'(bus.occ[0]), 5);

        // Fill bank 0 to the top, then push once more.
        for (int i = 0; i < 27; i++) begin
            bus.resp_valid   = 1'b1;
            bus.resp_slot_en = 2'b01;
            tick();
        end
        bus.resp_valid = 1'b0;
        #1;
        chk("top_occ0", 32'(bus.occ[0]), 32);
        chk("top_ovf",  32'(bus.overflow_err), 0);
        bus.resp_valid = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
        #1;
        chk("ovf_set",  32'(bus.overflow_err), 1);
        chk("ovf_occ0", 32'(bus.occ[0]), 32);
        tick();
        chk("ovf_sticky", 32'(bus.overflow_err), 1);
        bus.issue_ready = 2'b01;
        #1;
        chk("pre_rst_send", 32'(bus.send_inst_en), 1);

        // Asynchronous reset mid-cycle.
        bus.pc_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_occ0",  32'(bus.occ[0]), 0);
        chk("arst_ovf",   32'(bus.overflow_err), 0);
        chk("arst_send",  32'(bus.send_inst_en), 0);
        chk("arst_issue", 32'(bus.fetch_issue), 0);
        chk("arst_drain", 32'(bus.draining), 0);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
